serial_sub_ctrl: RTL and testbench

Bit-serial subtractor controller for the subtractor datapath. It captures two WIDTH-bit operands and a borrow-in on a start handshake. It then computes A − B − bin one bit per clock, LSB first, using a full-subtractor cell built from two half subtractors and a registered borrow. It sits between a requesting unit and the shared one-bit subtraction cell, and reports the difference, final borrow and zero flag with a one-cycle done pulse.

---
 rtl/serial_sub_ctrl.sv | 108 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes A - B - bin one bit per clock, LSB first,
// through a full-subtractor cell and a registered borrow.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    // state  | meaning
    // S_IDLE | waiting for start; results from the last operation held
    // S_RUN  | one bit subtracted per cycle, LSB first
    // S_DONE | done pulse for one cycle, results valid

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_nxt;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             bit_a, bit_b, hs_d, d, bnext;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Two cascaded half subtractors; their borrows are ORed into the next borrow.
    assign bit_a    = a_sh[0];
    assign bit_b    = b_sh[0];
    assign hs_d     = bit_a ^ bit_b;
    assign d        = hs_d ^ brw;
    assign bnext    = (~bit_a & bit_b) | (~hs_d & brw);
    assign diff_nxt = {d, diff_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // busy/done decode straight from the state register, so no input reaches them.
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            diff_sh    <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        brw     <= bin;
                        cnt     <= '0;
                        diff_sh <= '0;
                    end
                end
                S_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    brw     <= bnext;
                    cnt     <= cnt + CW'(1);
                    diff_sh <= diff_nxt;
                    if (last_bit) begin
                        borrow_out <= bnext;
                        zero       <= (diff_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_sh;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases plus random operands
// compared against plain-arithmetic expectations with cycle-exact handshake timing.
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic             bin;
    logic             busy, done, borrow_out, zero;
    logic [WIDTH-1:0] diff;

    int n_tests = 0;
    int n_fail  = 0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: unsigned subtraction modulo 2^WIDTH.
    task automatic expect_result(input int a, input int b, input int bi,
                                 output int e_diff, output int e_brw, output int e_zero);
        int raw;
        raw    = a - b - bi;
        e_diff = raw & ((1 << WIDTH) - 1);
        e_brw  = (a < b + bi) ? 1 : 0;
        e_zero = (e_diff == 0) ? 1 : 0;
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE, one cycle after done.
    task automatic run_op(input int a, input int b, input int bi);
        int e_diff, e_brw, e_zero;
        expect_result(a, b, bi, e_diff, e_brw, e_zero);
        start = 1'b1;
        a_in  = WIDTH'(a);
        b_in  = WIDTH'(b);
        bin   = bi[0];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        bin   = 1'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("diff", 32'(diff), 32'(e_diff));
        check("borrow_out", {31'd0, borrow_out}, 32'(e_brw));
        check("zero", {31'd0, zero}, 32'(e_zero));
        @(negedge clk);
        check("done_low", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("diff_hold", 32'(diff), 32'(e_diff));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h05, 8'h03, 0);
        run_op(8'h03, 8'h05, 0);
        run_op(8'h00, 8'h00, 1);
        run_op(8'h5A, 8'h5A, 0);
        run_op(8'hFF, 8'hFF, 1);
        run_op(8'h00, 8'hFF, 0);

        // start held high through RUN and DONE must not queue a second operation
        start = 1'b1;
        a_in  = 8'h10;
        b_in  = 8'h01;
        bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_in = 8'hFF;
        b_in = 8'h00;
        repeat (WIDTH) @(negedge clk);
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_diff", 32'(diff), 32'h0F);
        check("ign_borrow", {31'd0, borrow_out}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ign_no_busy", {31'd0, busy}, 32'd0);
            check("ign_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("ign_hold", 32'(diff), 32'h0F);

        // reset four cycles into RUN
        start = 1'b1;
        a_in  = 8'hC3;
        b_in  = 8'h21;
        bin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd0);
        check("mid_rst_borrow", {31'd0, borrow_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            check("post_rst_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        run_op(8'h80, 8'h01, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
